// File: rtl/hex_stream_fmt.sv
// +----------------------------------------------------------------------------+
// | hex_stream_fmt: buffers words and prints them as uppercase ASCII hex
// | with a separator and optional CR/LF, throttled by the UART tx_full.
// | Revision: 1.0
// +----------------------------------------------------------------------------+
`default_nettype none

module hex_stream_fmt #(
  parameter int         DATA_W         = 8,
  parameter int         FIFO_AW        = 2,
  parameter int         WORDS_PER_LINE = 16,
  parameter logic [7:0] SEP            = 8'h20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              tx_full,
  output logic              wr_uart,
  output logic [7:0]        w_data,
  output logic              drop_tick,
  output logic              busy
);

  localparam int ND    = DATA_W / 4;
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int DC_W  = (ND > 1) ? $clog2(ND) : 1;
  localparam int WC_W  = (WORDS_PER_LINE > 0) ? $clog2(WORDS_PER_LINE + 1) : 1;
  localparam bit              LINES_ON = (WORDS_PER_LINE > 0);
  localparam logic [DC_W-1:0] DC_INIT  = DC_W'(ND - 1);
  localparam logic [WC_W-1:0] WC_LAST  = (WORDS_PER_LINE > 0) ? WC_W'(WORDS_PER_LINE - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DIGIT = 3'd1,
    S_SEP   = 3'd2,
    S_CR    = 3'd3,
    S_LF    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DC_W-1:0]   dc_q, dc_d;
  logic [WC_W-1:0]   wc_q, wc_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [FIFO_AW:0]  wptr_q, rptr_q;
  logic              fifo_empty, fifo_full, pop, push;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Extra pointer MSB separates full (MSBs differ) from empty (all equal).
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = ((wptr_q ^ rptr_q) == {1'b1, {FIFO_AW{1'b0}}});
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  assign push       = din_valid && (!fifo_full || pop);
  assign drop_tick  = din_valid && fifo_full && !pop;
  assign busy       = !fifo_empty || (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[FIFO_AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      state_q <= S_IDLE;
      sh_q    <= '0;
      dc_q    <= '0;
      wc_q    <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      state_q <= state_d;
      sh_q    <= sh_d;
      dc_q    <= dc_d;
      wc_q    <= wc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    dc_d    = dc_q;
    wc_d    = wc_q;
    wr_uart = 1'b0;
    w_data  = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          sh_d    = mem_q[rptr_q[FIFO_AW-1:0]];
          dc_d    = DC_INIT;
          state_d = S_DIGIT;
        end
      end
      S_DIGIT: begin
        if (!tx_full) begin
          wr_uart = 1'b1;
          w_data  = hex_ascii(sh_q[DATA_W-1 -: 4]);
          sh_d    = sh_q << 4;
          dc_d    = dc_q - 1'b1;
          if (dc_q == '0) begin
            // The last word of a line is terminated by CR/LF instead of SEP.
            state_d = (LINES_ON && (wc_q == WC_LAST)) ? S_CR : S_SEP;
          end
        end
      end
      S_SEP: begin
        if (!tx_full) begin
          wr_uart = 1'b1;
          w_data  = SEP;
          wc_d    = wc_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      S_CR: begin
        if (!tx_full) begin
          wr_uart = 1'b1;
          w_data  = 8'h0D;
          state_d = S_LF;
        end
      end
      S_LF: begin
        if (!tx_full) begin
          wr_uart = 1'b1;
          w_data  = 8'h0A;
          wc_d    = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_hex_stream_fmt.sv
// +----------------------------------------------------------------------------+
// | tb_hex_stream_fmt: directed scoreboard bench for hex_stream_fmt.
// | Revision: 1.0
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_hex_stream_fmt;

  localparam int A_WPL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        vA, tfA, wrA, dropA, busyA;
  logic [7:0]  dA, wdA;
  logic        vB, tfB, wrB, dropB, busyB;
  logic [15:0] dB;
  logic [7:0]  wdB;

  logic [7:0]  qA[$];
  logic [7:0]  qB[$];
  int          wcA_m;
  logic        expDropA;
  int          checks, passes, fails, n;

  always #5 clk = ~clk;

  hex_stream_fmt #(.DATA_W(8), .FIFO_AW(2), .WORDS_PER_LINE(A_WPL), .SEP(8'h20)) dutA (
    .clk(clk), .reset(rst), .din(dA), .din_valid(vA), .tx_full(tfA),
    .wr_uart(wrA), .w_data(wdA), .drop_tick(dropA), .busy(busyA)
  );

  hex_stream_fmt #(.DATA_W(16), .FIFO_AW(2), .WORDS_PER_LINE(0), .SEP(8'h20)) dutB (
    .clk(clk), .reset(rst), .din(dB), .din_valid(vB), .tx_full(tfB),
    .wr_uart(wrB), .w_data(wdB), .drop_tick(dropB), .busy(busyB)
  );

  function automatic logic [7:0] asc(input logic [3:0] nib);
    if (nib <= 4'd9) return 8'd48 + 8'(nib);
    return 8'd65 + 8'(nib) - 8'd10;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [7:0] w);
    qA.push_back(asc(w[7:4]));
    qA.push_back(asc(w[3:0]));
    if (wcA_m == A_WPL - 1) begin
      qA.push_back(8'h0D);
      qA.push_back(8'h0A);
      wcA_m = 0;
    end else begin
      qA.push_back(8'h20);
      wcA_m++;
    end
  endtask

  task automatic push_b(input logic [15:0] w);
    for (int i = 3; i >= 0; i--) qB.push_back(asc(w[i*4 +: 4]));
    qB.push_back(8'h20);
  endtask

  task automatic mon();
    if (wrA) begin
      chk("A_write_while_full", 32'(tfA), 32'd0);
      if (qA.size() == 0) chk("A_unexpected_write", 32'(wrA), 32'd0);
      else chk("A_char", 32'(wdA), 32'(qA.pop_front()));
    end else begin
      chk("A_idle_data", 32'(wdA), 32'd0);
    end
    chk("A_drop", 32'(dropA), 32'(expDropA));
    if (wrB) begin
      chk("B_write_while_full", 32'(tfB), 32'd0);
      if (qB.size() == 0) chk("B_unexpected_write", 32'(wrB), 32'd0);
      else chk("B_char", 32'(wdB), 32'(qB.pop_front()));
    end else begin
      chk("B_idle_data", 32'(wdB), 32'd0);
    end
    chk("B_drop", 32'(dropB), 32'd0);
  endtask

  // Checks the current cycle's outputs, then advances to just after the next negedge.
  task automatic tick();
    #1;
    mon();
    @(negedge clk);
    #1;
  endtask

  task automatic drain(output int cnt);
    cnt = 0;
    while ((qA.size() != 0 || qB.size() != 0) && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("drain_timeout", 32'(qA.size() + qB.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; passes = 0; fails = 0;
    rst = 1'b0; vA = 1'b0; dA = '0; tfA = 1'b0;
    vB = 1'b0; dB = '0; tfB = 1'b0;
    expDropA = 1'b0; wcA_m = 0;

    // Reset state
    #1 rst = 1'b1;
    tick();
    tick();
    chk("A_reset_busy", 32'(busyA), 32'd0);
    chk("B_reset_busy", 32'(busyB), 32'd0);
    rst = 1'b0;
    tick();

    // Single byte 3A -> "3A "
    vA = 1'b1; dA = 8'h3A; push_a(8'h3A);
    tick();
    vA = 1'b0;
    drain(n);
    chk("A_single_latency", 32'(n), 32'd4);
    chk("A_single_busy", 32'(busyA), 32'd0);

    // Backpressure on 7F after the first digit
    vA = 1'b1; dA = 8'h7F; push_a(8'h7F);
    tick();
    vA = 1'b0;
    tick();
    tick();
    chk("A_bp_after_first", 32'(qA.size()), 32'd3);
    tfA = 1'b1;
    repeat (5) tick();
    chk("A_bp_held", 32'(qA.size()), 32'd3);
    tfA = 1'b0;
    drain(n);
    chk("A_bp_busy", 32'(busyA), 32'd0);

    // Line break every two words
    vA = 1'b1;
    dA = 8'hAA; push_a(8'hAA); tick();
    dA = 8'hBB; push_a(8'hBB); tick();
    dA = 8'hCC; push_a(8'hCC); tick();
    vA = 1'b0;
    drain(n);
    chk("A_line_busy", 32'(busyA), 32'd0);

    // Overflow: six back-to-back words, the sixth is dropped
    vA = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      dA = 8'(i);
      if (i <= 5) push_a(8'(i));
      else expDropA = 1'b1;
      tick();
    end
    expDropA = 1'b0;
    vA = 1'b0;
    drain(n);
    chk("A_ovf_busy", 32'(busyA), 32'd0);

    // 16-bit word BEEF
    vB = 1'b1; dB = 16'hBEEF; push_b(16'hBEEF);
    tick();
    vB = 1'b0;
    drain(n);
    chk("B_word_latency", 32'(n), 32'd6);
    chk("B_word_busy", 32'(busyB), 32'd0);

    // Reset after the first digit of 5C with two more words queued
    vA = 1'b1; dA = 8'h5C; qA.push_back(8'h35);
    tick();
    dA = 8'h11; tick();
    dA = 8'h22; tick();
    vA = 1'b0;
    rst = 1'b1;
    #1;
    chk("A_rst_wr", 32'(wrA), 32'd0);
    chk("A_rst_data", 32'(wdA), 32'd0);
    chk("A_rst_busy", 32'(busyA), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("A_post_rst_busy", 32'(busyA), 32'd0);
    chk("A_post_rst_queue", 32'(qA.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
